// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer shared by the IF and MEM pipeline stages.
// Define ARB_RR_EN to alternate grants on ties instead of fixed data priority.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_flush,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              d_req;
  logic              grant_data;
`ifdef ARB_RR_EN
  owner_e            last_grant_q, last_grant_d;
`endif

  assign d_req   = d_re | d_we;
  assign i_rdata = irdata_q;
  assign d_rdata = drdata_q;
  assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      irdata_q     <= '0;
      drdata_q     <= '0;
`ifdef ARB_RR_EN
      last_grant_q <= OWN_I;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      kill_q       <= kill_d;
      irdata_q     <= irdata_d;
      drdata_q     <= drdata_d;
`ifdef ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    kill_d     = kill_q;
    irdata_d   = irdata_q;
    drdata_d   = drdata_q;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    grant_data = d_req;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
    if (d_req && i_req) grant_data = (last_grant_q == OWN_I);
`endif

    case (state_q)
      S_IDLE: begin
        if (d_req || i_req) begin
          owner_d = grant_data ? OWN_D : OWN_I;
          addr_d  = grant_data ? d_addr : i_addr;
          we_d    = grant_data & d_we;
          wdata_d = d_wdata;
          state_d = S_ISSUE;
`ifdef ARB_RR_EN
          last_grant_d = grant_data ? OWN_D : OWN_I;
`endif
        end
      end
      S_ISSUE: begin
        m_en    = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (i_flush && owner_q == OWN_I) kill_d = 1'b1;
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_flush && owner_q == OWN_I) kill_d = 1'b1;
        // A killed fetch still captures its data; only the ready pulse is dropped.
        if (cnt_q == '0) begin
          if (owner_q == OWN_D) drdata_d = m_rdata;
          else                  irdata_d = m_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        i_ready = (owner_q == OWN_I) && !kill_q && !i_flush;
        d_ready = (owner_q == OWN_D);
        kill_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer that shares one unified memory between the pipeline's instruction-fetch (IF) stage and data-access (MEM) stage. It latches one request at a time and drives a fixed-latency memory. It returns read data with a one-cycle ready pulse and raises a global `stall` so the pipeline registers freeze while any access is outstanding. It sits between the CPU pipeline and the memory, replacing separate IM/DM ports.

## Interface
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width
- `MEM_LAT`, 2, number of cycles from the `m_en` cycle to the cycle where `m_rdata` is valid; must be ≥1

- `clk` in 1: global clock
- `rst_n` in 1: reset, synchronous and active-low
- `i_req` in 1: fetch request, held high until `i_ready`
- `i_addr` in ADDR_W: fetch address
- `i_flush` in 1: discard the in-flight or pending fetch result (taken branch)
- `i_rdata` out DATA_W: fetched instruction
- `i_ready` out 1: one-cycle pulse; `i_rdata` valid
- `d_re` in 1: data read request, held until `d_ready`
- `d_we` in 1: data write request, held until `d_ready`
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: data write value
- `d_rdata` out DATA_W: data read result
- `d_ready` out 1: one-cycle pulse; access complete
- `m_en` out 1: memory access strobe
- `m_we` out 1: memory write strobe
- `m_addr` out ADDR_W: memory address
- `m_wdata` out DATA_W: memory write data
- `m_rdata` in DATA_W: memory read data
- `stall` out 1: pipeline freeze

## Operation
- **Reset.** All outputs are 0, the FSM is IDLE, the wait counter is 0, `kill` is 0, and `last_grant` is set to I.
- **IDLE.** If the data port is requesting (`d_re|d_we`) or `i_req` is high, grant one requester:
  - Latch the owner, address, write flag and write data, then go to ISSUE.
  - Data beats instruction on a tie.
  - If `d_re` and `d_we` are both high, the access is a write.
- **ISSUE** (one cycle):
  - Drive `m_en=1`, `m_we` = the latched write flag, and `m_addr`/`m_wdata` from the latches.
  - A write goes straight to RESP.
  - A read loads the counter with `MEM_LAT-1` and goes to WAIT.
- **WAIT.** Decrement the counter each cycle.
  - When the counter reaches 0 and the state is WAIT, capture `m_rdata` into the owner's rdata register.
  - Then go to RESP.
- **RESP** (one cycle):
  - Pulse the owner's ready signal.
  - Go to IDLE next cycle. No grant is made in RESP, so a held request is never re-granted.
- **Latched fields.** Requester address and data changes after the grant are ignored.
- **Request dropped after grant.** The access completes and ready still pulses.
- **Request dropped before grant.** No access is made.
- **Flush.**
  - `i_flush` during ISSUE or WAIT of a fetch sets `kill`.
  - `i_ready = RESP & owner==I & ~kill & ~i_flush`.
  - `kill` clears on leaving RESP. `i_rdata` still updates.
  - `i_flush` has no effect on data accesses.
- **Stall.** `stall = (i_req & ~i_ready) | ((d_re|d_we) & ~d_ready)`.

## Timing
- A request is first seen in IDLE at cycle T.
  - `m_en` is high in T+1.
  - Read data is captured at the end of T+1+MEM_LAT.
  - Read ready pulses in T+2+MEM_LAT.
  - Write ready pulses in T+2.
- **Read throughput.** One read per MEM_LAT+3 cycles.
- **Write throughput.** One write per 3 cycles.
- `rdata` registers hold their value until the next read completes for that port.
- **Reset mid-access.** Abort to IDLE with `m_en=0` and no ready pulse. The result is discarded.

## Configuration
- **`ARB_RR_EN` defined.**
  - On a tie, grant the requester opposite to `last_grant`.
  - `last_grant` updates on every grant.
  - Data still wins first after reset.
- **`ARB_RR_EN` undefined.**
  - Fixed priority: data always wins ties.
  - `last_grant` is unused, and the instruction port may starve under back-to-back data traffic.

## Test plan
- **Fetch, MEM_LAT=2.** `i_req`, `i_addr`=0x0010, memory returns 0xA5A5 → `m_en` in T+1, `i_ready`=1 and `i_rdata`=0xA5A5 in T+4, `stall` high T..T+3.
- **Write.** `d_we`, `d_addr`=0x0040, `d_wdata`=0x1234 → `m_en`=`m_we`=1 with addr/data in T+1, `d_ready` in T+2, no `i_ready`.
- **Simultaneous `i_req` and `d_re` for 3 back-to-back pairs:**
  - Without `ARB_RR_EN`, data is granted first every time.
  - With `ARB_RR_EN`, grant order is D,I,D,I,D,I.
- **Flush.** `i_flush` pulsed in the WAIT cycle of a fetch → no `i_ready` pulse; FSM IDLE at T+5; next fetch completes normally.
- **Reset.** `rst_n`=0 during WAIT of a data read → next cycle all outputs 0, no `d_ready`. A subsequent read of 0x0040 returns 0x1234.
